cpu_stack_unit: RTL and testbench
=================================

CPU_STACK_UNIT -- requirements
Module: cpu_stack_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, giving the RAM address and PC width (legal 9..16).
REQ-002 SHALL have parameter STACK_LIMIT, default 9'h100, giving the lowest RAM address the stack may occupy.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset. Both are defined by REQ-004 and REQ-005.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-007 SHALL have port cmd_op, input, 2 bits: command code, 0=PUSH, 1=POP, 2=CALL, 3=RET.
REQ-008 SHALL have port cmd_ready, output, 1 bit: unit idle, command accepted this cycle if cmd_valid.
REQ-009 SHALL have port wdata, input, 8 bits: byte to PUSH.
REQ-010 SHALL have port call_pc, input, ADDR_WIDTH bits: return address to save on CALL.
REQ-011 SHALL have port rdata, output, 8 bits: byte returned by POP.
REQ-012 SHALL have port ret_pc, output, ADDR_WIDTH bits: address restored by RET.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port err, output, 1 bit: valid with done, marks an overflow or underflow rejection.
REQ-015 SHALL have port sp, output, ADDR_WIDTH bits: current stack pointer.
REQ-016 SHALL have RAM ports c_raddr (output, ADDR_WIDTH), c_waddr (output, ADDR_WIDTH), dwrite (output, 8), write_en (output, 1) and dread (input, 8); the RAM is synchronous with a registered address and 1-cycle read latency.

Function
REQ-017 SHALL use the constant NB = ceil(ADDR_WIDTH/8), the number of bytes per saved address.
REQ-018 SHALL drive cmd_ready high only in state IDLE; it accepts a command when cmd_valid && cmd_ready, capturing cmd_op, wdata and call_pc.
REQ-019 SHALL use the states IDLE, WRITE, READ and DONE; transitions are IDLE->WRITE (PUSH/CALL), IDLE->READ (POP/RET), WRITE->DONE, READ->DONE and DONE->IDLE.
REQ-020 SHALL complete PUSH as follows: in the cycle after accept, write_en=1, c_waddr=sp and dwrite=wdata, with sp<=sp-1.
REQ-021 SHALL write CALL as NB consecutive cycles, most significant byte first (zero-extended to 8*NB bits), each cycle writing at sp and decrementing sp.
REQ-022 SHALL complete POP as follows: in the cycle after accept, c_raddr=sp+1 and sp<=sp+1; dread is captured into rdata two cycles later.
REQ-023 SHALL issue RET reads to NB consecutive addresses sp+1..sp+NB back-to-back, least significant byte first, and assemble the captured bytes into ret_pc.
REQ-024 SHALL pulse done for exactly one cycle, in state DONE.
REQ-025 SHALL have these latencies from the accept edge to done high: PUSH 2 cycles; CALL NB+1 cycles; POP 4 cycles; RET NB+3 cycles.
REQ-026 SHALL hold rdata and ret_pc stable until the next POP or RET completes.
REQ-027 SHALL compute occupancy as all-ones minus sp (unsigned, ADDR_WIDTH bits); all-ones means empty.
REQ-028 SHALL reject a PUSH or CALL when sp-k+1 < STACK_LIMIT, where k is the number of bytes the command needs: no write, sp unchanged, done=1 and err=1 two cycles after accept.
REQ-029 SHALL reject a POP or RET when occupancy < k: no read, sp unchanged, rdata/ret_pc unchanged, done=1 and err=1 two cycles after accept.
REQ-030 SHALL keep write_en low in every cycle other than those of REQ-020 and REQ-021.
REQ-031 SHALL ignore cmd_valid while busy; holding cmd_valid high SHALL allow back-to-back commands with one idle cycle between them (DONE->IDLE).

Reset
REQ-032 SHALL, on reset assertion, asynchronously set: state=IDLE; sp=all-ones; c_raddr, c_waddr, dwrite, rdata, ret_pc = 0; write_en, done, err = 0.
REQ-033 SHALL abort any command in progress when reset is asserted mid-command, with no further RAM write and no done pulse.
REQ-034 SHALL drive cmd_ready high in the first clock edge after reset release.

Configuration
REQ-035 SHALL, with STACK_GUARD_EN defined, implement the REQ-028 and REQ-029 checks.
REQ-036 SHALL, without STACK_GUARD_EN, omit both checks, tie err to 0, and wrap sp modulo 2^ADDR_WIDTH on push past 0 or pop past all-ones.

Structure
REQ-037 SHALL take the cmd_op encodings (OP_PUSH, OP_POP, OP_CALL, OP_RET) and the state encoding from shared package cpu_pkg, to be reused by the CPU decoder.
REQ-038 SHALL be a single module with no sub-module; the NB byte counter and the address assembly are inline.

Verification
REQ-039 SHALL cover: ADDR_WIDTH=9, after reset, PUSH wdata=8'hA5 -> write at 9'h1FF, sp=9'h1FE, done 2 cycles after accept, err=0.
REQ-040 SHALL cover: CALL call_pc=9'h123 then RET -> writes 8'h01@1FF and 8'h23@1FE, then ret_pc=9'h123, sp=9'h1FF, RET done 5 cycles after accept.
REQ-041 SHALL cover: PUSH 8'h11, PUSH 8'h22, POP, POP -> rdata 8'h22 then 8'h11, sp back to 9'h1FF.
REQ-042 SHALL cover: STACK_GUARD_EN, POP immediately after reset -> done=1 and err=1, no read issued, sp=9'h1FF.
REQ-043 SHALL cover: STACK_GUARD_EN, STACK_LIMIT=9'h1FE, three PUSHes -> first two succeed; third returns err=1 and performs no write.
REQ-044 SHALL cover: rst low in the second write cycle of a CALL -> no further write_en, sp=9'h1FF, no done pulse.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU encodings: stack command opcodes, stack unit state encoding and
// the captured command payload. Reused by the CPU decoder.
package cpu_pkg;

   typedef enum logic [1:0] {
      OP_PUSH = 2'd0,
      OP_POP  = 2'd1,
      OP_CALL = 2'd2,
      OP_RET  = 2'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } stk_state_e;

   typedef struct packed {
      cmd_op_e    op;
      logic [7:0] data;
   } stk_cmd_t;

   // Bytes needed to hold one saved address of the given width.
   function automatic int unsigned addr_bytes(input int unsigned aw);
      return (aw + 7) / 8;
   endfunction

endpackage

// File: rtl/cpu_stack_unit.sv
// Byte-wide hardware stack for PUSH/POP/CALL/RET over a synchronous RAM.
// Define STACK_GUARD_EN to reject overflow/underflow; otherwise sp wraps.
module cpu_stack_unit
   import cpu_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 9,
   parameter logic [ADDR_WIDTH-1:0] STACK_LIMIT = ADDR_WIDTH'(9'h100)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   input  logic [1:0]            cmd_op,
   output logic                  cmd_ready,
   input  logic [7:0]            wdata,
   input  logic [ADDR_WIDTH-1:0] call_pc,
   output logic [7:0]            rdata,
   output logic [ADDR_WIDTH-1:0] ret_pc,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] sp,
   output logic [ADDR_WIDTH-1:0] c_raddr,
   output logic [ADDR_WIDTH-1:0] c_waddr,
   output logic [7:0]            dwrite,
   output logic                  write_en,
   input  logic [7:0]            dread
);

   localparam int unsigned NB = addr_bytes(ADDR_WIDTH);
   localparam int unsigned PW = 8 * NB;
   localparam int unsigned LW = PW - 8;
   localparam int unsigned EW = ADDR_WIDTH + 1;
   localparam int unsigned CW = 3;
`ifdef STACK_GUARD_EN
   localparam logic GUARD = 1'b1;
`else
   localparam logic GUARD = 1'b0;
`endif

   stk_state_e            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d, len_q, len_d;
   stk_cmd_t              cmd_q, cmd_d;
   logic                  rej_q, rej_d;
   logic [PW-1:0]         pc_q, pc_d;
   logic [LW-1:0]         lo_q, lo_d;
   logic [ADDR_WIDTH-1:0] sp_q, sp_d, raddr_q, raddr_d, waddr_q, waddr_d;
   logic [ADDR_WIDTH-1:0] ret_pc_q, ret_pc_d;
   logic [7:0]            dwrite_q, dwrite_d, rdata_q, rdata_d;
   logic                  wen_q, wen_d, done_q, done_d, err_q, err_d, ready_q, ready_d;

   cmd_op_e               op_c;
   logic                  is_wr_c;
   logic [CW-1:0]         len_c;
   logic [EW-1:0]         need_c;
   logic                  over_c, under_c;
   logic [7:0]            wbyte_c;

   // Command decode and stack-bound checks against the current sp.
   always_comb begin
      op_c    = cmd_op_e'(cmd_op);
      is_wr_c = (op_c == OP_PUSH) || (op_c == OP_CALL);
      len_c   = ((op_c == OP_CALL) || (op_c == OP_RET)) ? CW'(NB) : CW'(1);
      need_c  = EW'(len_c);
      over_c  = GUARD && ((EW'(sp_q) + EW'(1)) < (EW'(STACK_LIMIT) + need_c));
      under_c = GUARD && (EW'(~sp_q) < need_c);
   end

   // CALL bytes leave most significant first.
   always_comb begin
      wbyte_c = cmd_q.data;
      if (cmd_q.op == OP_CALL) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (cnt_q == CW'(NB - 1 - i)) wbyte_c = pc_q[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      cmd_d    = cmd_q;
      rej_d    = rej_q;
      pc_d     = pc_q;
      lo_d     = lo_q;
      sp_d     = sp_q;
      raddr_d  = raddr_q;
      waddr_d  = waddr_q;
      dwrite_d = dwrite_q;
      wen_d    = 1'b0;
      rdata_d  = rdata_q;
      ret_pc_d = ret_pc_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid && ready_q) begin
               cmd_d   = '{op: op_c, data: wdata};
               pc_d    = PW'(call_pc);
               len_d   = len_c;
               cnt_d   = '0;
               state_d = is_wr_c ? WRITE : READ;
               rej_d   = is_wr_c ? over_c : under_c;
            end
         end
         WRITE: begin
            cnt_d = cnt_q + CW'(1);
            if (rej_q) begin
               if (cnt_q == CW'(1)) state_d = DONE;
            end else if (cnt_q < len_q) begin
               wen_d    = 1'b1;
               waddr_d  = sp_q;
               dwrite_d = wbyte_c;
               sp_d     = sp_q - ADDR_WIDTH'(1);
            end else begin
               state_d = DONE;
            end
         end
         READ: begin
            cnt_d = cnt_q + CW'(1);
            if (rej_q) begin
               if (cnt_q == CW'(1)) state_d = DONE;
            end else begin
               if (cnt_q < len_q) begin
                  raddr_d = sp_q + ADDR_WIDTH'(1);
                  sp_d    = sp_q + ADDR_WIDTH'(1);
               end
               // Read data lags the issued address by two cycles, LSB byte first.
               for (int unsigned i = 0; i < NB - 1; i++) begin
                  if (cnt_q == CW'(i + 2)) lo_d[8*i +: 8] = dread;
               end
               if (cnt_q == len_q + CW'(1)) begin
                  if (cmd_q.op == OP_POP) rdata_d = dread;
                  else                    ret_pc_d = ADDR_WIDTH'({dread, lo_q});
               end
               if (cnt_q == len_q + CW'(2)) state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase
      done_d  = (state_d == DONE);
      err_d   = (state_d == DONE) && rej_q;
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         len_q    <= '0;
         cmd_q    <= '0;
         rej_q    <= 1'b0;
         pc_q     <= '0;
         lo_q     <= '0;
         sp_q     <= '1;
         raddr_q  <= '0;
         waddr_q  <= '0;
         dwrite_q <= '0;
         wen_q    <= 1'b0;
         rdata_q  <= '0;
         ret_pc_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         cmd_q    <= cmd_d;
         rej_q    <= rej_d;
         pc_q     <= pc_d;
         lo_q     <= lo_d;
         sp_q     <= sp_d;
         raddr_q  <= raddr_d;
         waddr_q  <= waddr_d;
         dwrite_q <= dwrite_d;
         wen_q    <= wen_d;
         rdata_q  <= rdata_d;
         ret_pc_q <= ret_pc_d;
         done_q   <= done_d;
         err_q    <= err_d;
         ready_q  <= ready_d;
      end
   end

   assign cmd_ready = ready_q;
   assign rdata     = rdata_q;
   assign ret_pc    = ret_pc_q;
   assign done      = done_q;
   assign err       = err_q;
   assign sp        = sp_q;
   assign c_raddr   = raddr_q;
   assign c_waddr   = waddr_q;
   assign dwrite    = dwrite_q;
   assign write_en  = wen_q;

endmodule

// File: tb/tb_cpu_stack_unit.sv
// Scoreboard bench for cpu_stack_unit with a behavioural synchronous RAM.
// Guard-specific cases follow STACK_GUARD_EN.
module tb_cpu_stack_unit;
   import cpu_pkg::*;

   localparam int unsigned   AW    = 9;
   localparam int unsigned   NB    = (AW + 7) / 8;
   localparam logic [AW-1:0] LIMIT = 9'h1FE;
   localparam int            AMAX  = (1 << AW) - 1;
`ifdef STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cmd_valid = 1'b0;
   logic [1:0]    cmd_op = 2'd0;
   logic          cmd_ready;
   logic [7:0]    wdata = 8'h00;
   logic [AW-1:0] call_pc = '0;
   logic [7:0]    rdata;
   logic [AW-1:0] ret_pc;
   logic          done, err;
   logic [AW-1:0] sp, c_raddr, c_waddr;
   logic [7:0]    dwrite;
   logic          write_en;
   logic [7:0]    dread;

   cpu_stack_unit #(.ADDR_WIDTH(AW), .STACK_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
      .cmd_ready(cmd_ready), .wdata(wdata), .call_pc(call_pc), .rdata(rdata),
      .ret_pc(ret_pc), .done(done), .err(err), .sp(sp), .c_raddr(c_raddr),
      .c_waddr(c_waddr), .dwrite(dwrite), .write_en(write_en), .dread(dread)
   );

   always #5 clk = ~clk;

   // RAM: registered read address, one-cycle read latency.
   logic [7:0]    ram [0:AMAX];
   logic [AW-1:0] ram_ra = '0;
   always @(posedge clk) begin
      if (write_en) ram[c_waddr] <= dwrite;
      ram_ra <= c_raddr;
   end
   assign dread = ram[ram_ra];

   typedef struct {
      string tag;
      int    lat;
      int    err;
      int    sp;
      int    rdata;
      int    ret_pc;
   } exp_t;
   typedef struct {
      int addr;
      int data;
   } wr_t;

   exp_t exp_q[$];
   wr_t  wr_q[$];
   int   m_mem [AMAX+1];
   int   m_sp, m_rdata, m_ret_pc;
   int   n_chk = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Every RAM write must match the next write the model predicted.
   always @(negedge clk) begin
      wr_t w;
      if (write_en === 1'b1) begin
         if (wr_q.size() == 0) begin
            check("wr_unexpected", write_en, 0);
         end else begin
            w = wr_q.pop_front();
            check("wr_addr", c_waddr, w.addr);
            check("wr_data", dwrite, w.data);
         end
      end
   end

   task automatic model_reset();
      m_sp = AMAX;
      m_rdata = 0;
      m_ret_pc = 0;
   endtask

   task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] wd,
                          input logic [AW-1:0] pc);
      exp_t e;
      wr_t  w;
      int   k, val, lat;
      bit   rej, seen;
      k = (op == OP_CALL || op == OP_RET) ? NB : 1;
      if (op == OP_PUSH || op == OP_CALL) rej = GUARD && ((m_sp - k + 1) < int'(LIMIT));
      else                                rej = GUARD && ((AMAX - m_sp) < k);
      e.tag = tag;
      e.err = rej;
      e.lat = 2;
      if (!rej) begin
         case (op)
            OP_PUSH: begin
               w.addr = m_sp; w.data = wd; wr_q.push_back(w);
               m_mem[m_sp] = wd;
               m_sp = (m_sp - 1) & AMAX;
            end
            OP_CALL: begin
               e.lat = NB + 1;
               for (int i = NB - 1; i >= 0; i--) begin
                  w.addr = m_sp; w.data = (int'(pc) >> (8 * i)) & 255; wr_q.push_back(w);
                  m_mem[m_sp] = w.data;
                  m_sp = (m_sp - 1) & AMAX;
               end
            end
            OP_POP: begin
               e.lat = 4;
               m_sp = (m_sp + 1) & AMAX;
               m_rdata = m_mem[m_sp];
            end
            default: begin
               e.lat = NB + 3;
               val = 0;
               for (int i = 0; i < NB; i++) begin
                  m_sp = (m_sp + 1) & AMAX;
                  val = val | (m_mem[m_sp] << (8 * i));
               end
               m_ret_pc = val & AMAX;
            end
         endcase
      end
      e.sp = m_sp;
      e.rdata = m_rdata;
      e.ret_pc = m_ret_pc;
      exp_q.push_back(e);

      for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) @(negedge clk);
      check({tag, "_ready"}, cmd_ready, 1);
      cmd_valid = 1'b1; cmd_op = op; wdata = wd; call_pc = pc;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 2'($urandom_range(3)); wdata = 8'($urandom); call_pc = AW'($urandom);
      lat = 0;
      seen = 1'b0;
      for (int i = 0; i < 16 && !seen; i++) begin
         if (done === 1'b1) seen = 1'b1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      e = exp_q.pop_front();
      check({e.tag, "_done"}, seen, 1);
      check({e.tag, "_lat"}, lat, e.lat);
      check({e.tag, "_err"}, err, e.err);
      check({e.tag, "_sp"}, sp, e.sp);
      check({e.tag, "_rdata"}, rdata, e.rdata);
      check({e.tag, "_retpc"}, ret_pc, e.ret_pc);
      @(negedge clk);
      check({e.tag, "_pulse"}, done, 0);
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      model_reset();
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [AW-1:0] raddr_before;
      for (int i = 0; i <= AMAX; i++) begin
         ram[i] = 8'(i ^ 8'h5A);
         m_mem[i] = (i ^ 8'h5A) & 255;
      end
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_sp", sp, AMAX);
      check("rst_wen", write_en, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_rdata", rdata, 0);
      check("rst_retpc", ret_pc, 0);
      check("rst_raddr", c_raddr, 0);
      check("rst_waddr", c_waddr, 0);
      check("rst_dwrite", dwrite, 0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_ready", cmd_ready, 1);

      run_cmd("push_a5", OP_PUSH, 8'hA5, '0);
      run_cmd("pop_a5", OP_POP, 8'h00, '0);
      run_cmd("call_123", OP_CALL, 8'h00, 9'h123);
      run_cmd("ret_123", OP_RET, 8'h00, '0);
      run_cmd("push_11", OP_PUSH, 8'h11, '0);
      run_cmd("push_22", OP_PUSH, 8'h22, '0);
      run_cmd("pop_22", OP_POP, 8'h00, '0);
      run_cmd("pop_11", OP_POP, 8'h00, '0);

      // Empty stack: rejected under the guard, wraps to address 0 otherwise.
      raddr_before = c_raddr;
      run_cmd("pop_empty", OP_POP, 8'h00, '0);
      if (GUARD) check("pop_empty_noread", c_raddr, raddr_before);
      run_cmd("ret_empty", OP_RET, 8'h00, '0);
      apply_reset();
      run_cmd("push_a", OP_PUSH, 8'h3C, '0);
      run_cmd("push_b", OP_PUSH, 8'hC3, '0);
      run_cmd("push_c", OP_PUSH, 8'h99, '0);
      run_cmd("call_lim", OP_CALL, 8'h00, 9'h0F0);

      for (int n = 0; n < 12; n++)
         run_cmd($sformatf("rnd%0d", n), 2'($urandom_range(3)), 8'($urandom), AW'($urandom));

      // Reset during the second byte write of a CALL.
      apply_reset();
      begin
         wr_t w;
         w.addr = AMAX; w.data = 8'h01; wr_q.push_back(w);
      end
      cmd_valid = 1'b1; cmd_op = OP_CALL; call_pc = 9'h1C7;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_wen", write_en, 0);
         check("abort_done", done, 0);
         check("abort_sp", sp, m_sp);
      end
      rst = 1'b1;
      @(negedge clk);
      check("abort_ready", cmd_ready, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_nodone", done, 0);
      end
      check("abort_ram", ram[AMAX], 8'h01);

      check("wq_empty", wr_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
